i2c_slave_reg_if: RTL and testbench

//  Synthesizable I2C slave. Sits on the same open-drain sda_io/scl_io wires as the APB-driven I2C master.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_sync_edge.sv | 31 +++
 rtl/i2c_slave_reg_if.sv | 163 ++++++++++++++++
 tb/tb_i2c_slave_reg_if.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus constants for the I2C slave
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_PTR,
    WR_DATA,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - multi-flop synchronizer with rise/fall pulses on the synced level
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Idle I2C lines are high, so start high to avoid a spurious edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '1;
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign q    = sync_r[SYNC_STAGES-1];
  assign rise = q & ~prev_r;
  assign fall = ~q & prev_r;

endmodule

// File: rtl/i2c_slave_reg_if.sv
// rtl/i2c_slave_reg_if.sv - I2C slave with register-pointer protocol and auto-increment
module i2c_slave_reg_if
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         PTR_W       = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             i2c_core_clock_i,
  input  logic             i2c_core_reset_n_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe_o,
  output logic             start_o,
  output logic             stop_o,
  output logic             wr_en_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic [PTR_W-1:0] rd_addr_o,
  input  logic [7:0]       rd_data_i
);

  logic scl_q, scl_rise, scl_fall;
  logic sda_q, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (i2c_core_clock_i),
    .rst_n (i2c_core_reset_n_i),
    .d     (scl_i),
    .q     (scl_q),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (i2c_core_clock_i),
    .rst_n (i2c_core_reset_n_i),
    .d     (sda_i),
    .q     (sda_q),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_state_e       state;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift_r;
  logic             rw_r;
  logic [PTR_W-1:0] ptr_r;

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_q;
  assign stop_det  = sda_rise & scl_q;
  assign rd_addr_o = ptr_r;

  always_ff @(posedge i2c_core_clock_i or negedge i2c_core_reset_n_i) begin
    if (!i2c_core_reset_n_i) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_r   <= '0;
      rw_r      <= 1'b0;
      ptr_r     <= '0;
      sda_oe_o  <= 1'b0;
      start_o   <= 1'b0;
      stop_o    <= 1'b0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      start_o <= 1'b0;
      stop_o  <= 1'b0;
      wr_en_o <= 1'b0;
      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        sda_oe_o <= 1'b0;
        start_o  <= 1'b1;
      end else if (stop_det) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        sda_oe_o <= 1'b0;
        stop_o   <= 1'b1;
      end else if (scl_rise) begin
        case (state)
          ADDR, WR_PTR, WR_DATA: begin
            if (bit_cnt != 4'd8) begin
              shift_r <= {shift_r[6:0], sda_q};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          RD_ACK: if (sda_q != I2C_ACK) state <= WAIT_STOP;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR: begin
            if (bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (shift_r[7:1] == SLAVE_ADDR) begin
                rw_r     <= shift_r[0];
                sda_oe_o <= 1'b1;
                state    <= ADDR_ACK;
              end else begin
                sda_oe_o <= 1'b0;
                state    <= WAIT_STOP;
              end
            end
          end
          // RD_ACK only survives to the fall when the master ACKed, so both reload here.
          ADDR_ACK, RD_ACK: begin
            if (state == RD_ACK || rw_r == I2C_RW_READ) begin
              shift_r  <= rd_data_i;
              sda_oe_o <= ~rd_data_i[7];
              bit_cnt  <= 4'd1;
              state    <= RD_BYTE;
            end else begin
              sda_oe_o <= 1'b0;
              bit_cnt  <= '0;
              state    <= WR_PTR;
            end
          end
          WR_PTR: begin
            if (bit_cnt == 4'd8) begin
              ptr_r    <= PTR_W'(shift_r);
              sda_oe_o <= 1'b1;
              bit_cnt  <= '0;
              state    <= WR_ACK;
            end
          end
          WR_DATA: begin
            if (bit_cnt == 4'd8) begin
              wr_addr_o <= ptr_r;
              wr_data_o <= shift_r;
              wr_en_o   <= 1'b1;
              ptr_r     <= ptr_r + PTR_W'(1);
              sda_oe_o  <= 1'b1;
              bit_cnt   <= '0;
              state     <= WR_ACK;
            end
          end
          WR_ACK: begin
            sda_oe_o <= 1'b0;
            bit_cnt  <= '0;
            state    <= WR_DATA;
          end
          RD_BYTE: begin
            if (bit_cnt == 4'd8) begin
              sda_oe_o <= 1'b0;
              ptr_r    <= ptr_r + PTR_W'(1);
              bit_cnt  <= '0;
              state    <= RD_ACK;
            end else begin
              shift_r  <= {shift_r[6:0], 1'b0};
              sda_oe_o <= ~shift_r[6];
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_reg_if.sv
// tb/tb_i2c_slave_reg_if.sv - bus-level master, register file, reference model and scoreboard
module tb_i2c_slave_reg_if;

  localparam int         Q     = 40;
  localparam logic [6:0] SLAVE = 7'h50;
  localparam logic [7:0] EV_S  = 8'h53;
  localparam logic [7:0] EV_P  = 8'h50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_low = 1'b0;
  logic       sda_oe, start_p, stop_p, wr_en;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       sda_line;
  logic [7:0] regfile [256];
  logic       mem_ready = 1'b0;

  logic [7:0]  model_mem [256];
  logic [7:0]  model_ptr;
  logic [15:0] wr_q [$];
  logic [7:0]  ev_q [$];
  logic [7:0]  tx [$];
  int          checks = 0;
  int          errors = 0;
  logic        quiet = 1'b0;
  int          quiet_hits = 0;

  assign sda_line = ~(m_low | sda_oe);
  assign rd_data  = regfile[rd_addr];

  always #5 clk = ~clk;

  i2c_slave_reg_if dut (
    .i2c_core_clock_i   (clk),
    .i2c_core_reset_n_i (rst_n),
    .scl_i              (m_scl),
    .sda_i              (sda_line),
    .sda_oe_o           (sda_oe),
    .start_o            (start_p),
    .stop_o             (stop_p),
    .wr_en_o            (wr_en),
    .wr_addr_o          (wr_addr),
    .wr_data_o          (wr_data),
    .rd_addr_o          (rd_addr),
    .rd_data_i          (rd_data)
  );

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) regfile[i] <= ~8'(i);
      mem_ready <= 1'b1;
    end else if (wr_en) begin
      regfile[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops expected bus events and register writes as the DUT pulses them.
  initial begin
    logic [7:0]  e;
    logic [15:0] w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (start_p || stop_p) begin
          if (ev_q.size() == 0) check("unexpected_event", {start_p, stop_p}, 0);
          else begin
            e = ev_q.pop_front();
            check("bus_event", start_p ? EV_S : EV_P, e);
          end
        end
        if (wr_en) begin
          if (wr_q.size() == 0) check("unexpected_wr", {wr_addr, wr_data}, 0);
          else begin
            w = wr_q.pop_front();
            check("wr_addr_data", {wr_addr, wr_data}, w);
          end
        end
        if (quiet && sda_oe) quiet_hits++;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic wbit(input logic b);
    #Q; m_low = ~b;
    #Q; m_scl = 1'b1;
    #(2*Q); m_scl = 1'b0;
  endtask

  task automatic rbit(output logic b);
    #Q; m_low = 1'b0;
    #Q; m_scl = 1'b1;
    #Q; b = sda_line;
    #Q; m_scl = 1'b0;
  endtask

  task automatic bus_start();
    ev_q.push_back(EV_S);
    #Q; m_low = 1'b0;
    #Q; m_scl = 1'b1;
    #Q; m_low = 1'b1;
    #Q; m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    ev_q.push_back(EV_P);
    #Q; m_low = 1'b1;
    #Q; m_scl = 1'b1;
    #Q; m_low = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(a);
    check(name, a, exp_ack);
  endtask

  // First byte of tx is the pointer, the rest are data; the model is updated before the bytes go out.
  task automatic xfer_write(input logic [6:0] a7, input logic do_stop);
    logic match;
    match = (a7 == SLAVE);
    bus_start();
    send_byte({a7, 1'b0}, ~match, "addr_ack");
    foreach (tx[i]) begin
      if (match) begin
        if (i == 0) model_ptr = tx[i];
        else begin
          wr_q.push_back({model_ptr, tx[i]});
          model_mem[model_ptr] = tx[i];
          model_ptr = model_ptr + 8'd1;
        end
      end
      send_byte(tx[i], ~match, "data_ack");
    end
    if (do_stop) bus_stop();
  endtask

  task automatic xfer_read(input int n);
    logic [7:0] got;
    logic       b;
    bus_start();
    send_byte({SLAVE, 1'b1}, 1'b0, "rd_addr_ack");
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        rbit(b);
        got[i] = b;
      end
      check("rd_byte", got, model_mem[model_ptr]);
      model_ptr = model_ptr + 8'd1;
      wbit(k == n - 1);
    end
    bus_stop();
    check("sda_released", sda_oe, 1'b0);
  endtask

  initial begin
    logic [7:0] p;
    int         kind, n;
    for (int i = 0; i < 256; i++) model_mem[i] = ~8'(i);
    model_ptr = 8'h00;

    repeat (4) @(negedge clk);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_start", start_p, 1'b0);
    check("rst_stop", stop_p, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_ptr", rd_addr, 8'h00);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    tx = '{8'h03, 8'hA5, 8'h5A};
    xfer_write(SLAVE, 1'b1);
    check("t1_ptr", rd_addr, 8'h05);

    xfer_read(1);
    check("t6_ptr", rd_addr, model_ptr);

    tx = '{8'($urandom), 8'($urandom)};
    quiet = 1'b1;
    xfer_write(7'h51, 1'b1);
    quiet = 1'b0;
    check("t2_no_sda_drive", quiet_hits, 0);

    tx = '{8'h10};
    xfer_write(SLAVE, 1'b0);
    xfer_read(3);
    check("t3_ptr", rd_addr, 8'h13);

    tx = '{8'hFF, 8'($urandom), 8'($urandom)};
    xfer_write(SLAVE, 1'b1);
    check("t4_ptr_wrap", rd_addr, model_ptr);

    bus_start();
    send_byte({SLAVE, 1'b0}, 1'b0, "t5_addr_ack");
    p = 8'($urandom);
    model_ptr = p;
    send_byte(p, 1'b0, "t5_ptr_ack");
    for (int i = 0; i < 4; i++) wbit(1'($urandom));
    bus_stop();
    check("t5_sda_after_stop", sda_oe, 1'b0);
    check("t5_ptr_kept", rd_addr, model_ptr);

    bus_start();
    for (int i = 7; i >= 0; i--) wbit(p[i] ^ p[i]);
    for (int i = 7; i >= 0; i--) wbit(1'(8'hA0 >> i));
    #Q;
    check("t5_ack_driven", sda_oe, 1'b0);
    bus_start();
    for (int i = 7; i >= 0; i--) wbit(1'(8'hA0 >> i));
    #Q;
    check("t5_ack_driven2", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_async_release", sda_oe, 1'b0);
    check("t5_rst_ptr", rd_addr, 8'h00);
    model_ptr = 8'h00;
    m_low = 1'b0;
    m_scl = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int t = 0; t < 10; t++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 3);
      if (kind == 0) begin
        tx.delete();
        for (int i = 0; i <= n; i++) tx.push_back(8'($urandom));
        xfer_write(SLAVE, 1'b1);
      end else if (kind == 1) begin
        xfer_read(n);
      end else begin
        tx = '{8'($urandom), 8'($urandom)};
        xfer_write(SLAVE ^ 7'($urandom_range(1, 127)), 1'b1);
      end
      check("rand_ptr", rd_addr, model_ptr);
    end

    repeat (20) @(negedge clk);
    check("wr_q_drained", wr_q.size(), 0);
    check("ev_q_drained", ev_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
